// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 pins, frames bytes,
// decodes make/break/extended prefixes and keeps a 6-bit held-key vector.
// Optional: define PS2_PARITY_CHECK_EN to reject frames whose 9 bits are not odd parity.
module ps2_key_tracker #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [5:0] key_status,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_s;
  logic          dat_s;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          filt_flip;
  logic          fall;
  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          par_ok;
  logic          brk;
  logic          ext;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // Two-flop synchronizers on both pins; idle-high so reset loads ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
    end
  end

  // The filtered clock flips on the FILTER_LEN-th consecutive sample that disagrees with it.
  assign filt_flip = (clk_s != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign fall      = filt_flip && filt_clk;

  // Glitch filter on the PS/2 clock; shorter disagreements are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      filt_clk <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  // Odd parity over data plus parity bit means the XOR reduction is 1.
  assign par_ok = ^{shreg, par_bit};

  // Parity bit captured on the PARITY-state fall for the stop-bit decision.
  always_ff @(posedge clk) begin
    if (rst)                         par_bit <= 1'b0;
    else if (fall && state == PARITY) par_bit <= dat_s;
  end
`else
  assign par_ok = 1'b1;
`endif

  // Frame receiver: advances on filtered falls; aborts mid-frame when falls stop arriving.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      tmo_cnt    <= '0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        // A fall always wins over a coincident timeout.
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            if (!dat_s) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            shreg  <= {dat_s, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: state <= STOP;
          STOP: begin
            if (dat_s && par_ok) begin
              scan_code  <= shreg;
              scan_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_hit) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        tmo_cnt   <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // Scan-code decoder: prefix flags plus the held-key map, updated the cycle after each accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_status <= '0;
      brk        <= 1'b0;
      ext        <= 1'b0;
    end else if (frame_err) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (scan_valid) begin
      case (scan_code)
        8'hF0: brk <= 1'b1;
        8'hE0: ext <= 1'b1;
        8'hAA: begin
          key_status <= '0;
          brk        <= 1'b0;
          ext        <= 1'b0;
        end
        default: begin
          if (!ext) begin
            case (scan_code)
              8'h1D:   key_status[0] <= ~brk;
              8'h1C:   key_status[1] <= ~brk;
              8'h1B:   key_status[2] <= ~brk;
              8'h23:   key_status[3] <= ~brk;
              8'h29:   key_status[4] <= ~brk;
              8'h5A:   key_status[5] <= ~brk;
              default: ;
            endcase
          end
          brk <= 1'b0;
          ext <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: PS/2 frame driver, key-map reference model,
// and an event scoreboard checked by an independent monitor.
module tb_ps2_key_tracker;

  localparam int HALF    = 50;
  localparam int TIMEOUT = 400;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk_in = 1'b1;
  logic       ps2_dat_in = 1'b1;
  logic [5:0] key_status;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  ps2_key_tracker #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .key_status(key_status), .scan_code(scan_code),
    .scan_valid(scan_valid), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
    logic [5:0] keys;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  bit [5:0] m_keys = '0;
  bit       m_brk  = 1'b0;
  bit       m_ext  = 1'b0;
  bit [7:0] m_last = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int key_index(input bit [7:0] c);
    case (c)
      8'h1D: return 0;
      8'h1C: return 1;
      8'h1B: return 2;
      8'h23: return 3;
      8'h29: return 4;
      8'h5A: return 5;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_keys = '0; m_brk = 1'b0; m_ext = 1'b0; m_last = '0;
    exp_q.delete();
  endtask

  task automatic expect_err();
    m_brk = 1'b0; m_ext = 1'b0;
    exp_q.push_back({1'b1, m_last, m_keys});
  endtask

  task automatic expect_byte(input bit [7:0] c, input bit par_bad, input bit stop_bad);
    int idx;
    if (stop_bad || (par_bad && PCHK)) begin
      expect_err();
    end else begin
      if (c == 8'hF0) m_brk = 1'b1;
      else if (c == 8'hE0) m_ext = 1'b1;
      else if (c == 8'hAA) begin m_keys = '0; m_brk = 1'b0; m_ext = 1'b0; end
      else begin
        idx = key_index(c);
        if (!m_ext && idx >= 0) m_keys[idx] = !m_brk;
        m_brk = 1'b0; m_ext = 1'b0;
      end
      m_last = c;
      exp_q.push_back({1'b0, c, m_keys});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input bit b);
    ps2_dat_in = b;
    tick(HALF);
    ps2_clk_in = 1'b0;
    tick(HALF);
    ps2_clk_in = 1'b1;
  endtask

  task automatic send_frame(input bit [7:0] c, input bit par_bad, input bit stop_bad);
    expect_byte(c, par_bad, stop_bad);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(c[i]);
    bit_out((~^c) ^ par_bad);
    bit_out(!stop_bad);
    ps2_dat_in = 1'b1;
    tick(HALF);
  endtask

  task automatic send_partial(input bit [7:0] c, input int nbits);
    bit_out(1'b0);
    for (int i = 0; i < nbits; i++) bit_out(c[i]);
    ps2_dat_in = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
      exp_q.delete();
    end
    tick(4);
  endtask

  // Monitor: every output event must match the head of the scoreboard queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (scan_valid || frame_err)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: valid=%0b err=%0b code=0x%0h, required no event",
                   scan_valid, frame_err, scan_code);
        end else begin
          e = exp_q.pop_front();
          chk("event_err", {31'd0, frame_err}, {31'd0, e.is_err});
          chk("event_valid", {31'd0, scan_valid}, {31'd0, !e.is_err});
          chk("scan_code", {24'd0, scan_code}, {24'd0, e.code});
          @(negedge clk);
          chk("key_status", {26'd0, key_status}, {26'd0, e.keys});
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    @(negedge clk);
    chk({tag, "_keys"}, {26'd0, key_status}, 32'd0);
    chk({tag, "_code"}, {24'd0, scan_code}, 32'd0);
    chk({tag, "_valid"}, {31'd0, scan_valid}, 32'd0);
    chk({tag, "_err"}, {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    bit [7:0] pick [10];
    bit [7:0] c;
    pick = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A, 8'hF0, 8'hE0, 8'hAA, 8'h00};

    tick(5);
    check_outputs_zero("reset");
    rst = 1'b0;
    tick(20);

    // W make, then break; Space make/break
    send_frame(8'h1D, 0, 0); drain();
    send_frame(8'hF0, 0, 0); send_frame(8'h1D, 0, 0); drain();
    send_frame(8'h29, 0, 0); drain();
    send_frame(8'hF0, 0, 0); send_frame(8'h29, 0, 0); drain();

    // Extended keypad Enter ignored, main Enter held
    send_frame(8'hE0, 0, 0); send_frame(8'h5A, 0, 0); drain();
    send_frame(8'h5A, 0, 0); drain();

    // A with a wrong parity bit
    send_frame(8'h1C, 1, 0); drain();

    // Frame abandoned after 4 data bits -> timeout error, then D
    expect_err();
    send_partial(8'h23, 4);
    tick(3 * TIMEOUT);
    drain();
    send_frame(8'h23, 0, 0); drain();

    // Short glitches on the PS/2 clock while idle must not start a frame
    ps2_clk_in = 1'b0; tick(1); ps2_clk_in = 1'b1; tick(30);
    ps2_clk_in = 1'b0; tick(5); ps2_clk_in = 1'b1; tick(30);
    send_frame(8'h1B, 0, 0); drain();

    // BAT pass clears held keys
    send_frame(8'hAA, 0, 0); drain();
    send_frame(8'h1D, 0, 0); send_frame(8'h29, 0, 0); drain();

    // Reset in the middle of a frame
    send_partial(8'h1B, 3);
    rst = 1'b1;
    model_reset();
    tick(3);
    check_outputs_zero("midreset");
    rst = 1'b0;
    ps2_clk_in = 1'b1;
    tick(20);
    send_frame(8'h1D, 0, 0); drain();

    // Randomized traffic
    for (int i = 0; i < 20; i++) begin
      c = pick[$urandom_range(0, 9)];
      if (c == 8'h00) c = 8'($urandom_range(0, 255));
      send_frame(c, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
      drain();
    end

    tick(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
